ps2_key_encoder: RTL and testbench

- Converts a raw PS/2 keyboard serial stream into the 11-bit toggle-strobe `ps2_key` word that the core's key-mapping logic consumes.
- It is the producing end of that interface: it receives and validates frames, strips E0/F0/E1 prefixes and emits one `ps2_key` update per make or break event.
- It sits between the board PS/2 pins (or a bench model of them) and the emu-level key decoder.

---
 rtl/ps2_key_encoder.sv | 188 ++++++++++++++++++
 tb/tb_ps2_key_encoder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard receiver and scan-code encoder.
// Turns the raw PS/2 clock/data pair into the toggle-strobe ps2_key word:
// synchronise, de-glitch the clock, shift in 11-bit frames, then strip the
// E0/F0 prefixes and swallow the E1 pause sequence.
module ps2_key_encoder #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 100000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_PAUSE  = 1'b1
    } state_t;

    // synchronisers (never reset)
    logic          r_clk_s1, r_clk_s2;
    logic          r_dat_s1, r_dat_s2;
    // clock glitch filter
    logic          r_clk_f;
    logic [FW-1:0] r_flt_cnt;
    logic          r_fall;
    // frame receiver
    logic [3:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_par;
    logic [TW-1:0] r_to_cnt;
    logic          r_byte_vld;
    logic [7:0]    r_byte;
    logic          r_rx_err;
    // decoder
    state_t        r_state, w_state_nx;
    logic [2:0]    r_skip, w_skip_nx;
    logic          r_ext, w_ext_nx;
    logic          r_brk, w_brk_nx;
    logic [10:0]   r_key, w_key_nx;
    logic          w_ignore;

    // Two-flop synchronisers bring both asynchronous lines into clk_sys.
    always_ff @(posedge clk_sys) begin
        r_clk_s1 <= ps2_clk;
        r_clk_s2 <= r_clk_s1;
        r_dat_s1 <= ps2_data;
        r_dat_s2 <= r_dat_s1;
    end

    // Filtered clock flips only after FILTER_LEN consecutive differing samples;
    // r_fall is high in the cycle the filtered clock has just dropped to 0.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_clk_f   <= 1'b1;
            r_flt_cnt <= '0;
            r_fall    <= 1'b0;
        end else begin
            r_fall <= 1'b0;
            if (r_clk_s2 != r_clk_f) begin
                if (r_flt_cnt == FLT_LAST) begin
                    r_clk_f   <= r_clk_s2;
                    r_flt_cnt <= '0;
                    r_fall    <= ~r_clk_s2;
                end else begin
                    r_flt_cnt <= r_flt_cnt + 1'b1;
                end
            end else begin
                r_flt_cnt <= '0;
            end
        end
    end

    // Frame receiver: start/data/parity/stop on each fall, plus mid-frame timeout.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_bit_cnt  <= 4'd0;
            r_to_cnt   <= '0;
            r_byte_vld <= 1'b0;
            r_rx_err   <= 1'b0;
        end else begin
            r_byte_vld <= 1'b0;
            r_rx_err   <= 1'b0;
            if (r_fall) begin
                r_to_cnt <= '0;
                if (r_bit_cnt == 4'd0) begin
                    // a high start bit is line noise: stay idle without complaint
                    if (!r_dat_s2) r_bit_cnt <= 4'd1;
                end else if (r_bit_cnt <= 4'd8) begin
                    r_shift   <= {r_dat_s2, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end else if (r_bit_cnt == 4'd9) begin
                    r_par     <= r_dat_s2;
                    r_bit_cnt <= 4'd10;
                end else begin
                    r_bit_cnt <= 4'd0;
                    if (r_dat_s2 && (^{r_shift, r_par})) begin
                        r_byte_vld <= 1'b1;
                        r_byte     <= r_shift;
                    end else begin
                        r_rx_err <= 1'b1;
                    end
                end
            end else if (r_bit_cnt != 4'd0) begin
                if (r_to_cnt == TO_LAST) begin
                    r_bit_cnt <= 4'd0;
                    r_to_cnt  <= '0;
                    r_rx_err  <= 1'b1;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    // Status bytes (BAT, ACK, echo, resend, overrun) are dropped unless prefixed.
    assign w_ignore = (r_byte inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF})
                      && !r_ext && !r_brk;

    // Decoder next-state: prefix flags, pause-sequence skipping and event emission.
    always_comb begin
        w_state_nx = r_state;
        w_skip_nx  = r_skip;
        w_ext_nx   = r_ext;
        w_brk_nx   = r_brk;
        w_key_nx   = r_key;
        if (r_rx_err) begin
            w_state_nx = ST_NORMAL;
            w_skip_nx  = 3'd0;
            w_ext_nx   = 1'b0;
            w_brk_nx   = 1'b0;
        end else if (r_byte_vld) begin
            case (r_state)
                ST_NORMAL: begin
                    if (r_byte == 8'hE0) begin
                        w_ext_nx = 1'b1;
                    end else if (r_byte == 8'hF0) begin
                        w_brk_nx = 1'b1;
                    end else if (r_byte == 8'hE1) begin
                        // Pause has no break code: report one extended make of 77
                        w_state_nx = ST_PAUSE;
                        w_skip_nx  = 3'd7;
                        w_key_nx   = {~r_key[10], 1'b1, 1'b1, 8'h77};
                    end else if (!w_ignore) begin
                        w_key_nx = {~r_key[10], ~r_brk, r_ext, r_byte};
                        w_ext_nx = 1'b0;
                        w_brk_nx = 1'b0;
                    end
                end
                ST_PAUSE: begin
                    w_skip_nx = r_skip - 3'd1;
                    if (r_skip == 3'd1) w_state_nx = ST_NORMAL;
                end
                default: w_state_nx = ST_NORMAL;
            endcase
        end
    end

    // Decoder state register.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= ST_NORMAL;
            r_skip  <= 3'd0;
            r_ext   <= 1'b0;
            r_brk   <= 1'b0;
            r_key   <= 11'd0;
        end else begin
            r_state <= w_state_nx;
            r_skip  <= w_skip_nx;
            r_ext   <= w_ext_nx;
            r_brk   <= w_brk_nx;
            r_key   <= w_key_nx;
        end
    end

    assign ps2_key = r_key;
    assign err     = r_rx_err;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Bench for ps2_key_encoder: drives PS/2 frames bit by bit and compares the
// key word, event count and error count with a byte-level reference model.
module tb_ps2_key_encoder;

    localparam int FLT  = 8;
    localparam int TO   = 1000;
    localparam int HALF = 30;

    logic        clk_sys  = 1'b0;
    logic        reset    = 1'b1;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        err;

    ps2_key_encoder #(.FILTER_LEN(FLT), .TIMEOUT(TO)) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .ps2_key  (ps2_key),
        .err      (err)
    );

    always #5 clk_sys = ~clk_sys;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // observed activity, sampled on the falling edge
    logic [10:0] prev_key = 11'd0;
    logic        prev_err = 1'b0;
    int tog_cnt = 0, err_cnt = 0, err_wide = 0, last_tog_cyc = 0;

    always @(negedge clk_sys) begin
        if (!reset && ps2_key[10] !== prev_key[10]) begin
            tog_cnt++;
            last_tog_cyc = cyc;
        end
        if (err === 1'b1 && prev_err !== 1'b1) err_cnt++;
        if (err === 1'b1 && prev_err === 1'b1) err_wide++;
        prev_key = ps2_key;
        prev_err = err;
    end

    // reference model state
    logic [10:0] m_key = 11'd0;
    bit  m_ext = 0, m_brk = 0;
    int  m_skip = 0;
    int  exp_tog = 0, exp_err = 0;
    int  last_stop = 0;

    function automatic bit is_status(input logic [7:0] b);
        return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) ||
               (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
    endfunction

    task automatic model_byte(input logic [7:0] b);
        if (m_skip > 0) begin
            m_skip--;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'hE1) begin
            m_skip = 7;
            m_key  = {~m_key[10], 1'b1, 1'b1, 8'h77};
            exp_tog++;
        end else if (!(is_status(b) && !m_ext && !m_brk)) begin
            m_key = {~m_key[10], ~m_brk, m_ext, b};
            exp_tog++;
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic model_error();
        exp_err++;
        m_ext  = 0;
        m_brk  = 0;
        m_skip = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) @(negedge clk_sys);
        #1;
    endtask

    // drive the first nbits of an 11-bit frame (bit 0 = start) on the lines
    task automatic send_bits(input logic [10:0] frm, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = frm[i];
            cyc_wait(HALF);
            ps2_clk = 1'b0;
            if (i == 10) last_stop = cyc;
            cyc_wait(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".key"}, 32'(ps2_key), 32'(m_key));
        check({tag, ".tog"}, tog_cnt, exp_tog);
        check({tag, ".err"}, err_cnt, exp_err);
    endtask

    // kind: 0 good, 1 bad parity, 2 bad stop bit
    task automatic frame(input logic [7:0] b, input int kind, input string tag);
        logic par;
        logic stp;
        par = ~^b;
        if (kind == 1) par = ~par;
        stp = (kind != 2);
        send_bits({stp, par, b, 1'b0}, 11);
        if (kind == 0) model_byte(b);
        else           model_error();
        cyc_wait(HALF);
        check_state(tag);
    endtask

    initial begin
        logic [7:0] rb;
        logic [7:0] pause_seq [8];
        logic [7:0] status_tab [6];
        int r;
        pause_seq  = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        status_tab = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

        // reset state
        cyc_wait(4);
        check("rst.key", 32'(ps2_key), 32'd0);
        check("rst.err", 32'(err), 32'd0);
        reset = 1'b0;
        cyc_wait(4);

        // single make code and its latency from the stop-bit fall
        frame(8'h1C, 0, "t1");
        check("t1.raw", 32'(ps2_key), 32'h61C);
        check("t1.lat", last_tog_cyc - last_stop, 2 + FLT + 2);

        // break and extended prefixes
        frame(8'hF0, 0, "t2a");
        frame(8'h1C, 0, "t2b");
        check("t2b.lo", 32'(ps2_key[9:0]), 32'h01C);
        frame(8'hE0, 0, "t2c");
        frame(8'h75, 0, "t2d");
        check("t2d.lo", 32'(ps2_key[9:0]), 32'h375);
        frame(8'hE0, 0, "t2e");
        frame(8'hF0, 0, "t2f");
        frame(8'h75, 0, "t2g");
        check("t2g.lo", 32'(ps2_key[9:0]), 32'h175);

        // parity error then recovery
        frame(8'h1C, 1, "t3a");
        frame(8'h2D, 0, "t3b");
        check("t3b.lo", 32'(ps2_key[9:0]), 32'h22D);

        // mid-frame timeout
        send_bits({1'b1, ~^8'h55, 8'h55, 1'b0}, 5);
        cyc_wait(TO + 60);
        model_error();
        check_state("t4a");
        frame(8'h29, 0, "t4b");
        check("t4b.lo", 32'(ps2_key[9:0]), 32'h229);

        // pause sequence gives one event
        for (int i = 0; i < 8; i++) frame(pause_seq[i], 0, "t5p");
        check("t5.lo", 32'(ps2_key[9:0]), 32'h377);
        frame(8'h1C, 0, "t5n");

        // short clock glitches while idle
        for (int g = 2; g < FLT - 1; g++) begin
            ps2_clk = 1'b0;
            cyc_wait(g);
            ps2_clk = 1'b1;
            cyc_wait(20);
        end
        check_state("t6g");
        frame(8'h4B, 0, "t6h");

        // reset in the middle of a frame
        send_bits({1'b1, ~^8'h33, 8'h33, 1'b0}, 7);
        reset = 1'b1;
        cyc_wait(3);
        reset = 1'b0;
        m_key = 11'd0; m_ext = 0; m_brk = 0; m_skip = 0;
        cyc_wait(5);
        check_state("t6r");
        frame(8'h16, 0, "t6s");
        check("t6s.lo", 32'(ps2_key[9:0]), 32'h216);

        // randomized byte stream
        for (int n = 0; n < 30; n++) begin
            r  = int'($urandom_range(0, 99));
            rb = 8'($urandom);
            if      (r < 15) frame(8'hE0, 0, "rnd");
            else if (r < 27) frame(8'hF0, 0, "rnd");
            else if (r < 31) frame(8'hE1, 0, "rnd");
            else if (r < 41) frame(status_tab[$urandom_range(0, 5)], 0, "rnd");
            else if (r < 46) frame(rb, int'($urandom_range(1, 2)), "rnd");
            else             frame(rb, 0, "rnd");
        end

        check("errwide", err_wide, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

endmodule
